// File: rtl/heatmap_render_pkg.sv
// Shared geometry, widths and palette mapping for the heatmap renderer.
// Optional grid-line overlay is enabled by defining HEATMAP_GRID_LINES_EN.
package heatmap_render_pkg;
    localparam int H_ACTIVE = 480;
    localparam int V_ACTIVE = 272;
    localparam int GRID_W   = 16;
    localparam int GRID_H   = 8;
    localparam int CELL_W   = H_ACTIVE / GRID_W;
    localparam int CELL_H   = V_ACTIVE / GRID_H;
    localparam int CELLS    = GRID_W * GRID_H;
    localparam int ADDR_W   = $clog2(CELLS);
    localparam int CX_W     = $clog2(GRID_W);
    localparam int CY_W     = $clog2(GRID_H);
    localparam int PX_W     = $clog2(CELL_W);
    localparam int PY_W     = $clog2(CELL_H);
    localparam int R_W      = 5;
    localparam int G_W      = 6;
    localparam int B_W      = 5;
    localparam int RGB_W    = R_W + G_W + B_W;
    localparam logic VS_POL_DEF = 1'b0;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // Blue -> green for the lower half of the range, green -> red for the upper half.
    function automatic rgb565_t palette_map(input logic [7:0] m);
        rgb565_t c;
        if (!m[7]) begin
            c.r = '0;
            c.g = m[6:1];
            c.b = ~m[6:2];
        end else begin
            c.r = m[6:2];
            c.g = ~m[6:1];
            c.b = '0;
        end
        return c;
    endfunction
endpackage

// File: rtl/heatmap_palette.sv
// Registered magnitude -> RGB565 palette stage (1 cycle), with blanking and a white override.
module heatmap_palette
    import heatmap_render_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             white_i,
    input  logic [7:0]       m_i,
    output logic [RGB_W-1:0] rgb_o
);
    logic [RGB_W-1:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (en_i) begin
            if (white_i) rgb_d = '1;
            else         rgb_d = palette_map(m_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_q <= '0;
        else        rgb_q <= rgb_d;
    end

    assign rgb_o = rgb_q;
endmodule

// File: rtl/heatmap_render.sv
// Pixel-stage heatmap renderer: position tracking, double-buffered cell RAM, palette output.
// Define HEATMAP_GRID_LINES_EN to draw white lines on the first pixel/line of every cell.
module heatmap_render
    import heatmap_render_pkg::*;
#(
    parameter logic VS_POL = VS_POL_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              swap_req,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [RGB_W-1:0]  rgb,
    output logic              front_bank,
    output logic              swap_done
);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(CELL_H - 1);
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(GRID_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(GRID_H - 1);

    logic            vs_q, de_prev_q;
    logic [PX_W-1:0] px_q, px_d;
    logic [CX_W-1:0] cx_q, cx_d;
    logic [PY_W-1:0] py_q, py_d;
    logic [CY_W-1:0] cy_q, cy_d;
    logic            front_q, front_d, pending_q, pending_d, done_q, done_d;
    logic [1:0]      hs_dl_q, vs_dl_q, de_dl_q;
    logic [7:0]      rd_q;
    logic            fs, de_fall, wr_ok, white;
    logic [ADDR_W-1:0] rd_addr;

    assign fs      = (vs_q != VS_POL) && (vs_in == VS_POL);
    assign de_fall = de_prev_q && !de_in;
    assign rd_addr = {cy_q, cx_q};

    always_comb begin
        px_d = '0;
        cx_d = '0;
        if (de_in) begin
            cx_d = cx_q;
            if (px_q == PX_LAST) begin
                px_d = '0;
                if (cx_q != CX_LAST) cx_d = cx_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end

        py_d = py_q;
        cy_d = cy_q;
        if (fs) begin
            py_d = '0;
            cy_d = '0;
        end else if (de_fall) begin
            if (py_q == PY_LAST) begin
                py_d = '0;
                if (cy_q != CY_LAST) cy_d = cy_q + 1'b1;
            end else begin
                py_d = py_q + 1'b1;
            end
        end

        // A request arriving in the fs cycle itself is honoured immediately.
        front_d   = front_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        if (fs && (pending_q || swap_req)) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
            done_d    = 1'b1;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= VS_POL;
            de_prev_q <= 1'b0;
            px_q      <= '0;
            cx_q      <= '0;
            py_q      <= '0;
            cy_q      <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            hs_dl_q   <= '0;
            vs_dl_q   <= '0;
            de_dl_q   <= '0;
        end else begin
            vs_q      <= vs_in;
            de_prev_q <= de_in;
            px_q      <= px_d;
            cx_q      <= cx_d;
            py_q      <= py_d;
            cy_q      <= cy_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            hs_dl_q   <= {hs_dl_q[0], hs_in};
            vs_dl_q   <= {vs_dl_q[0], vs_in};
            de_dl_q   <= {de_dl_q[0], de_in};
        end
    end

    generate
        if (CELLS < (1 << ADDR_W)) begin : g_addr_chk
            assign wr_ok = (wr_addr < ADDR_W'(CELLS));
        end else begin : g_addr_full
            assign wr_ok = 1'b1;
        end
    endgenerate

    // Bank is the address MSB; writes always target the bank not on screen.
    logic [7:0] mem [0:2*CELLS-1];
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) mem[{~front_q, wr_addr}] <= wr_data;
        rd_q <= mem[{front_q, rd_addr}];
    end

`ifdef HEATMAP_GRID_LINES_EN
    logic grid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grid_q <= 1'b0;
        else        grid_q <= de_in && ((px_q == '0) || (py_q == '0));
    end
    assign white = grid_q;
`else
    assign white = 1'b0;
`endif

    heatmap_palette u_palette (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (de_dl_q[0]),
        .white_i (white),
        .m_i     (rd_q),
        .rgb_o   (rgb)
    );

    assign hs_out     = hs_dl_q[1];
    assign vs_out     = vs_dl_q[1];
    assign de_out     = de_dl_q[1];
    assign front_bank = front_q;
    assign swap_done  = done_q;
endmodule

// File: tb/tb_heatmap_render.sv
// Directed bench for heatmap_render: reset, bank swaps, cell colours, grid lines, latency.
`timescale 1ns/1ps
module tb_heatmap_render;
    localparam int LINES = 70;
    localparam int PIX   = 96;
    localparam int NV    = 13;
`ifdef HEATMAP_GRID_LINES_EN
    localparam bit GRID_EN = 1'b1;
`else
    localparam bit GRID_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
    logic wr_en = 1'b0, swap_req = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic hs_out, vs_out, de_out, front_bank, swap_done;
    logic [15:0] rgb;

    int checks = 0;
    int failures = 0;

    heatmap_render dut (
        .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .rgb(rgb),
        .front_bank(front_bank), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output-side monitor: places every de_out pixel on its screen position.
    logic [15:0] cap [0:LINES-1][0:PIX-1];
    int ox = 0, oy = 0, swaps = 0;
    logic vs_prev = 1'b0, de_prev = 1'b0;
    always @(negedge clk) begin
        if (de_prev && !de_out) begin oy++; ox = 0; end
        if (vs_prev && !vs_out) begin oy = 0; ox = 0; end
        if (de_out) begin
            if (ox < PIX && oy < LINES) cap[oy][ox] = rgb;
            ox++;
        end
        if (swap_done) swaps++;
        vs_prev = vs_out;
        de_prev = de_out;
    end

    typedef struct {
        int x;
        int y;
        logic [15:0] base;
    } vec_t;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] grid_exp(input int x, input int y, input logic [15:0] base);
        if (GRID_EN && ((x % 30) == 0 || (y % 34) == 0)) return 16'hFFFF;
        return base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input logic [6:0] a, input logic [7:0] d);
        step();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drive_frame(input bit req_at_fs, input bit wr_at_fs,
                               input logic [6:0] wa, input logic [7:0] wd);
        step();
        vs_in = 1'b0;
        if (req_at_fs) swap_req = 1'b1;
        if (wr_at_fs) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        step();
        if (req_at_fs) swap_req = 1'b0;
        if (wr_at_fs) wr_en = 1'b0;
        step();
        vs_in = 1'b1;
        repeat (2) step();
        for (int l = 0; l < LINES; l++) begin
            hs_in = 1'b0;
            step();
            hs_in = 1'b1;
            repeat (2) step();
            de_in = 1'b1;
            repeat (PIX) step();
            de_in = 1'b0;
            repeat (3) step();
        end
        repeat (3) step();
    endtask

    task automatic check_px(input string tag, input int x, input int y, input logic [15:0] base);
        check($sformatf("%s px(%0d,%0d)", tag, x, y), {16'h0, cap[y][x]}, {16'h0, grid_exp(x, y, base)});
    endtask

    task automatic check_tbl(input string tag);
        for (int i = 0; i < NV; i++) check_px(tag, tbl[i].x, tbl[i].y, tbl[i].base);
    endtask

    initial begin
        int s0;
        tbl[0]  = '{0, 0, 16'hF800};   tbl[1]  = '{29, 33, 16'hF800};
        tbl[2]  = '{29, 0, 16'hF800};  tbl[3]  = '{0, 33, 16'hF800};
        tbl[4]  = '{30, 0, 16'h040F};  tbl[5]  = '{30, 5, 16'h040F};
        tbl[6]  = '{0, 34, 16'h9360};  tbl[7]  = '{7, 34, 16'h9360};
        tbl[8]  = '{30, 34, 16'h001F}; tbl[9]  = '{59, 67, 16'h001F};
        tbl[10] = '{60, 34, 16'h07E0}; tbl[11] = '{89, 67, 16'h07E0};
        tbl[12] = '{45, 50, 16'h001F};

        // Reset held while timing is live.
        for (int i = 0; i < 8; i++) begin
            step();
            de_in = i[0];
            hs_in = ~i[1];
        end
        @(negedge clk);
        check("reset rgb", {16'h0, rgb}, 32'h0);
        check("reset de_out", {31'h0, de_out}, 32'h0);
        check("reset front_bank", {31'h0, front_bank}, 32'h0);
        check("reset swap_done", {31'h0, swap_done}, 32'h0);
        step();
        de_in = 1'b0; hs_in = 1'b1; rst_n = 1'b1;
        repeat (3) step();

        // Fill back bank 1, then swap it in at the next frame start.
        write_cell(7'd0, 8'd255);
        write_cell(7'd1, 8'd64);
        write_cell(7'd16, 8'd200);
        write_cell(7'd17, 8'd0);
        write_cell(7'd18, 8'd128);
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        s0 = swaps;
        drive_frame(1'b0, 1'b0, 7'd0, 8'd0);
        check("f1 swap count", swaps - s0, 32'd1);
        check("f1 front_bank", {31'h0, front_bank}, 32'h1);
        check_tbl("f1");

        // Two requests plus back-bank writes while bank 1 is on screen.
        s0 = swaps;
        fork
            drive_frame(1'b0, 1'b0, 7'd0, 8'd0);
            begin
                repeat (300) step();
                swap_req = 1'b1;
                step();
                swap_req = 1'b0;
                write_cell(7'd0, 8'd0);
                write_cell(7'd17, 8'd255);
                repeat (2000) step();
                swap_req = 1'b1;
                step();
                swap_req = 1'b0;
            end
        join
        check("f2 swap count", swaps - s0, 32'd0);
        check("f2 front_bank", {31'h0, front_bank}, 32'h1);
        check_tbl("f2");

        s0 = swaps;
        drive_frame(1'b0, 1'b0, 7'd0, 8'd0);
        check("f3 swap count", swaps - s0, 32'd1);
        check("f3 front_bank", {31'h0, front_bank}, 32'h0);
        check_px("f3", 5, 5, 16'h001F);
        check_px("f3", 45, 50, 16'hF800);

        // Request and write both in the frame-start cycle.
        s0 = swaps;
        drive_frame(1'b1, 1'b1, 7'd0, 8'd128);
        check("f4 swap count", swaps - s0, 32'd1);
        check("f4 front_bank", {31'h0, front_bank}, 32'h1);
        check_px("f4", 5, 5, 16'h07E0);
        check_px("f4", 45, 50, 16'h001F);

        // Input-to-output delay of the sync signals.
        step();
        de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        repeat (2) @(negedge clk);
        check("lat1 de_out", {31'h0, de_out}, 32'h0);
        check("lat1 hs_out", {31'h0, hs_out}, 32'h1);
        check("lat1 vs_out", {31'h0, vs_out}, 32'h1);
        @(negedge clk);
        check("lat2 de_out", {31'h0, de_out}, 32'h1);
        check("lat2 hs_out", {31'h0, hs_out}, 32'h0);
        check("lat2 vs_out", {31'h0, vs_out}, 32'h0);
        step();
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/heatmap_render.md
# heatmap_render

Pixel-stage renderer sitting directly downstream of the LCD timing generator on the 480x272 panel path. Consumes the generator's hs/vs/de, tracks the active pixel position, looks up the acoustic-power value of the grid cell under that pixel from a double-buffered cell memory written by the beamformer, and emits RGB565 through a blue-green-red palette, with sync signals delayed to match. Bank swaps happen only at frame start, so the panel never shows a half-updated map.

## Interface
- H_ACTIVE, 480: active pixels per line
- V_ACTIVE, 272: active lines per frame
- GRID_W, 16: cells per row; CELL_W = H_ACTIVE/GRID_W = 30
- GRID_H, 8: cell rows; CELL_H = V_ACTIVE/GRID_H = 34
- VS_POL, 1'b0: vs_in active level; frame start = vs_in entering VS_POL
- clk  in  1  pixel clock (9 MHz)
- rst_n  in  1  asynchronous, active-low reset (one clock; reset async active-low)
- hs_in / vs_in / de_in  in  1 each  timing from generator
- wr_en  in  1  cell write strobe (back bank)
- wr_addr  in  7  cell index = row*GRID_W + col
- wr_data  in  8  power magnitude, 0..255
- swap_req  in  1  one-cycle request to swap banks at next frame start
- hs_out / vs_out / de_out  out  1 each  inputs delayed 2 cycles
- rgb  out  16  RGB565 {r5,g6,b5}
- front_bank  out  1  bank currently displayed
- swap_done  out  1  one-cycle pulse when a swap executes

## Operation
- Reset values: hs_out=0, vs_out=0, de_out=0, rgb=0, front_bank=0, swap_done=0, swap_pending=0, all counters 0. Cell memory not reset; contents undefined until written.
- Frame start (fs): vs_in registered; fs = previous != VS_POL and current == VS_POL.
- Position: px/cx (pixel within cell 0..CELL_W-1, cell column 0..GRID_W-1) advance on each de_in=1 cycle; px wraps at CELL_W-1 and increments cx; cx saturates at GRID_W-1. Both clear on de_in=0.
- Line: py/cy (line within cell, cell row) advance on de_in falling edge, same wrap/saturate rule with CELL_H/GRID_H; clear on fs. No dividers.
- Read address = cy*GRID_W + cx (shift, GRID_W power of two), bank = front_bank.
- Writes: wr_en writes wr_data to wr_addr in bank ~front_bank. Writes never touch the front bank. wr_addr >= GRID_W*GRID_H ignored.
- Swap: swap_req sets swap_pending; on fs with pending (or swap_req same cycle as fs), front_bank toggles, pending clears, swap_done pulses. Multiple requests in one frame collapse into one swap. Write in the fs cycle lands in the pre-toggle back bank.
- Palette, magnitude m: m<128: r5=0, g6=m[6:1], b5=~m[6:2]. m>=128: r5=m[6:2], g6=~m[6:1], b5=0.
- rgb = 0 whenever de_out=0.

## Timing
- Stage 0: counters + address registered-read issue; stage 1: memory read data; stage 2: palette register to rgb.
- Latency de_in -> de_out/rgb: 2 cycles; hs/vs delayed identically, pixel-aligned.
- Swap takes effect for the first active pixel after fs; front_bank changes the cycle after fs is detected.
- rst_n deassert mid-frame: renderer resyncs at next fs; until then y is counted from 0 (image offset, acceptable).

## Configuration
- HEATMAP_GRID_LINES_EN defined: pixels with px==0 or py==0 inside the active area output rgb=16'hFFFF (white grid lines), overriding palette; pipeline latency unchanged.
- Not defined: all active pixels palette-colored; no grid-line logic synthesized.

## Structure
- Shared package/include: H_ACTIVE/V_ACTIVE/GRID_W/GRID_H defaults, derived CELL_W/CELL_H, address width, RGB565 field widths.
- One sub-module: heatmap_palette (registered m -> RGB565, 1 cycle), reused by future legend rendering. Cell memory inferred as simple dual-port RAM, 256x8 (2 banks x 128).

## Test plan
- Reset: hold rst_n=0 with live timing -> rgb=0, de_out=0, front_bank=0, swap_done=0.
- Write bank 1 cell 0 = 255, swap_req, run to fs -> swap_done pulse, front_bank=1, pixel (0,0)..(29,33) rgb=16'hF800.
- Cell 17 (row1,col1) = 0 -> pixels x 30..59, y 34..67 rgb=16'h001F; cell 18 = 128 -> 16'h07E0.
- swap_req twice in one frame -> exactly one swap; back-bank writes during display leave visible frame unchanged.
- de_in to de_out/rgb delay exactly 2 cycles; hs_out/vs_out same delay.
- With HEATMAP_GRID_LINES_EN: x=30,y=5 and x=7,y=34 -> 16'hFFFF; without: palette color.
